// File: rtl/flash_read_arbiter_pkg.sv
// flash_read_arbiter_pkg: shared flash constants, arbiter states and sizing helper
package flash_read_arbiter_pkg;
  localparam int FLASH_ADDR_WIDTH = 24;
  localparam logic [7:0] RESP_ERR_BYTE = 8'hFF;
  typedef enum logic [1:0] {
    WAIT_SETUP = 2'd0,
    IDLE       = 2'd1,
    READ       = 2'd2,
    GAP        = 2'd3
  } arb_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/flash_read_arbiter_rr_pick.sv
// flash_read_arbiter_rr_pick: round-robin winner search starting after last grant
module flash_read_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(last) + k) % N]) begin
        any = 1'b1;
        idx = IW'((int'(last) + k) % N);
        gnt[(int'(last) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: round-robin sharing of the qspi_flash read port with per-read timeout
module flash_read_arbiter
  import flash_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = FLASH_ADDR_WIDTH,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [7:0]                    resp_data,
  output logic                          resp_err,
  output logic                          busy,
  input  logic                          flash_setup_done,
  input  logic                          flash_data_ready,
  input  logic [7:0]                    flash_data,
  output logic [ADDR_WIDTH-1:0]         flash_addr,
  output logic                          flash_do_read
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT) + 1;
  arb_state_t state;
  logic [IW-1:0] last_grant, grant, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic pick_any;
  logic [TW-1:0] timer;
  flash_read_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .last(last_grant),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );
  // accept is combinational so the requester sees req_ready in the cycle it wins
  assign req_ready = (state == IDLE && flash_setup_done && pick_any) ? pick_gnt : '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= WAIT_SETUP;
      last_grant    <= IW'(NUM_REQ - 1);
      grant         <= '0;
      timer         <= '0;
      flash_addr    <= '0;
      flash_do_read <= 1'b0;
      resp_valid    <= '0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (!flash_setup_done) begin
        state         <= WAIT_SETUP;
        flash_do_read <= 1'b0;
        busy          <= 1'b1;
        if (state == READ) begin
          resp_valid <= NUM_REQ'(1) << grant;
          resp_data  <= RESP_ERR_BYTE;
          resp_err   <= 1'b1;
          last_grant <= grant;
        end
      end else begin
        case (state)
          WAIT_SETUP: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          IDLE: begin
            busy <= pick_any;
            if (pick_any) begin
              flash_addr    <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
              grant         <= pick_idx;
              flash_do_read <= 1'b1;
              timer         <= '0;
              state         <= READ;
            end
          end
          READ: begin
            timer <= (timer == '1) ? timer : timer + TW'(1);
            // data_ready outranks an expiring timer in the same cycle
            if (flash_data_ready || timer == TW'(TIMEOUT - 1)) begin
              resp_valid    <= NUM_REQ'(1) << grant;
              resp_data     <= flash_data_ready ? flash_data : RESP_ERR_BYTE;
              resp_err      <= !flash_data_ready;
              flash_do_read <= 1'b0;
              last_grant    <= grant;
              state         <= GAP;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: randomized transaction-level check of flash_read_arbiter against a reference model
module tb_flash_read_arbiter;
  localparam int NR = 2;
  localparam int AW = 24;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0] req_ready, resp_valid;
  logic [7:0] resp_data;
  logic resp_err, busy;
  logic flash_setup_done = 1'b0;
  logic flash_data_ready;
  logic [7:0] flash_data;
  logic [AW-1:0] flash_addr;
  logic flash_do_read;
  logic spur = 1'b0;
  int lat_r = 0;
  int cnt;
  logic [7:0] fbyte = 8'h00;
  logic [AW-1:0] a [NR];
  int model_last = NR - 1;
  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  flash_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .flash_setup_done(flash_setup_done),
    .flash_data_ready(flash_data_ready), .flash_data(flash_data),
    .flash_addr(flash_addr), .flash_do_read(flash_do_read)
  );

  // flash model: byte ready on the lat_r-th cycle of do_read high; lat_r=0 never answers
  always @(posedge clk or negedge resetn)
    if (!resetn) cnt <= 0;
    else cnt <= flash_do_read ? cnt + 1 : 0;
  assign flash_data_ready = spur | (flash_do_read && lat_r != 0 && cnt + 1 == lat_r);
  assign flash_data = fbyte;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] m, input int last);
    for (int k = 1; k <= NR; k++)
      if (m[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  // called at posedge+1; in_gap means the previous cycle delivered a response
  task automatic run_txn(input logic [NR-1:0] mask, input int lat, input bit in_gap, input int abort_at);
    int w, n, d;
    bit err;
    req_addr = {a[1], a[0]};
    req_valid = mask;
    lat_r = lat;
    if (in_gap) begin
      #1 chk("gap_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
    end
    w = pick(mask, model_last);
    #1 chk("grant", 32'(req_ready), 32'(1 << w));
    @(posedge clk); #1;
    req_valid = '0;
    chk("do_read", 32'(flash_do_read), 1);
    chk("addr", 32'(flash_addr), 32'(a[w]));
    chk("busy_read", 32'(busy), 1);
    err = abort_at != 0 || lat == 0 || lat > TO;
    d = abort_at != 0 ? abort_at + 1 : (err ? TO : lat);
    n = 0;
    while (resp_valid == 0 && n < TO + 8) begin
      if (abort_at != 0 && n == abort_at) flash_setup_done = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, d);
    chk("resp_valid", 32'(resp_valid), 32'(1 << w));
    chk("resp_data", 32'(resp_data), err ? 32'hFF : 32'(fbyte));
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("do_read_low", 32'(flash_do_read), 0);
    model_last = w;
    if (abort_at != 0) begin
      chk("abort_busy", 32'(busy), 1);
      req_valid = '1;
      repeat (3) begin
        @(posedge clk); #1;
        chk("setup_ready", 32'(req_ready), 0);
      end
      flash_setup_done = 1'b1;
      req_valid = '0;
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_data();
    a[0] = AW'($urandom);
    a[1] = AW'($urandom);
    fbyte = 8'($urandom);
  endtask

  initial begin
    int r, lat;
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_do_read", 32'(flash_do_read), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    resetn = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("wait_setup_ready", 32'(req_ready), 0);
      chk("wait_setup_busy", 32'(busy), 1);
    end
    req_valid = '0;
    flash_setup_done = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 0);
    a[0] = 24'h012345; a[1] = 24'h00ABCD; fbyte = 8'h5A;
    run_txn(2'b01, 40, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      rand_data();
      run_txn(2'b11, $urandom_range(1, 20), 1'b1, 0);
    end
    rand_data();
    run_txn(2'b10, 0, 1'b1, 0);
    rand_data();
    run_txn(2'b11, TO, 1'b1, 0);
    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    chk("spur_resp", 32'(resp_valid), 0);
    chk("spur_busy", 32'(busy), 0);
    rand_data();
    run_txn(2'b01, 0, 1'b0, 7);
    for (int i = 0; i < 16; i++) begin
      rand_data();
      r = $urandom_range(0, 9);
      lat = r == 0 ? 0 : r == 1 ? TO : r == 2 ? TO + $urandom_range(1, 5) : $urandom_range(1, 50);
      run_txn(NR'($urandom_range(1, 3)), lat, i != 0, 0);
    end
    @(posedge clk); #1;
    lat_r = 0;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b11;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("mid_rst_do_read", 32'(flash_do_read), 0);
    chk("mid_rst_addr", 32'(flash_addr), 0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 0);
    chk("mid_rst_resp_data", 32'(resp_data), 0);
    chk("mid_rst_resp_err", 32'(resp_err), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    model_last = NR - 1;
    req_valid = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 0);
    rand_data();
    run_txn(2'b11, 12, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
